// File: rtl/prog_loader.sv
// Program loader: assembles a length-prefixed byte stream into 16-bit words and writes them
// to instruction memory from address 0, holding the CPU in reset until done. Optional macro: LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_START,
  input  logic [7:0]        i_BYTE,
  input  logic              i_BYTE_VALID,
  output logic              o_BYTE_READY,
  output logic              o_MEM_WE,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic [15:0]       o_MEM_DATA,
  output logic              o_CPU_RST,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_next;
  logic [15:0]       data_next;
  logic              ready_next, we_next, busy_next, done_next, err_next;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  // The ready register always mirrors "current state takes a byte".
  assign accept = i_BYTE_VALID & o_BYTE_READY;

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    addr_next  = o_MEM_ADDR;
    data_next  = o_MEM_DATA;
`ifdef LOADER_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_START) state_next = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (i_BYTE == 8'd0) begin
            state_next = S_ERR;
          end else begin
            len_next   = i_BYTE;
            cnt_next   = 8'd0;
            addr_next  = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_next  = 8'd0;
`endif
            state_next = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          data_next[15:8] = i_BYTE;
`ifdef LOADER_CHECKSUM_EN
          csum_next       = csum_reg ^ i_BYTE;
`endif
          state_next      = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          data_next[7:0] = i_BYTE;
`ifdef LOADER_CHECKSUM_EN
          csum_next      = csum_reg ^ i_BYTE;
`endif
          state_next     = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_next = cnt_reg + 8'd1;
        if (cnt_next == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else begin
          addr_next  = o_MEM_ADDR + ADDR_W'(1);
          state_next = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_next = (i_BYTE == csum_reg) ? S_DONE : S_ERR;
      end
`endif
      default: state_next = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state they describe.
    ready_next = (state_next == S_LEN) || (state_next == S_HI) || (state_next == S_LO)
`ifdef LOADER_CHECKSUM_EN
                 || (state_next == S_CHK)
`endif
                 ;
    we_next    = (state_next == S_WRITE);
    done_next  = (state_next == S_DONE);
    err_next   = (state_next == S_ERR);
    busy_next  = (state_next != S_IDLE) && !done_next && !err_next;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_reg    <= S_IDLE;
      len_reg      <= 8'd0;
      cnt_reg      <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg     <= 8'd0;
`endif
      o_BYTE_READY <= 1'b0;
      o_MEM_WE     <= 1'b0;
      o_MEM_ADDR   <= '0;
      o_MEM_DATA   <= 16'd0;
      o_CPU_RST    <= 1'b0;
      o_BUSY       <= 1'b0;
      o_DONE       <= 1'b0;
      o_ERR        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
`ifdef LOADER_CHECKSUM_EN
      csum_reg     <= csum_next;
`endif
      o_BYTE_READY <= ready_next;
      o_MEM_WE     <= we_next;
      o_MEM_ADDR   <= addr_next;
      o_MEM_DATA   <= data_next;
      o_CPU_RST    <= done_next;
      o_BUSY       <= busy_next;
      o_DONE       <= done_next;
      o_ERR        <= err_next;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random load sessions compared against
// a stream-level reference model (expected word writes and session outcome).
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_d = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_we, cpu_rst, busy, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;

  prog_loader #(.ADDR_W(8)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_START(start), .i_BYTE(byte_d),
    .i_BYTE_VALID(byte_valid), .o_BYTE_READY(byte_ready), .o_MEM_WE(mem_we),
    .o_MEM_ADDR(mem_addr), .o_MEM_DATA(mem_data), .o_CPU_RST(cpu_rst),
    .o_BUSY(busy), .o_DONE(done), .o_ERR(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [7:0]  stream_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  bit          exp_ok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe; ready must be low and busy high while writing.
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) begin
      got_q.push_back({mem_addr, mem_data});
      check("ready_in_write", 32'(byte_ready), 32'd0);
      check("busy_in_write", 32'(busy), 32'd1);
    end
  end

  // Reference: stream -> list of (addr, word) writes and success flag.
  task automatic model_stream();
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'(stream_q[0]);
    exp_ok = 1'b0;
    if (n != 0) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({8'(i), stream_q[1 + 2 * i], stream_q[2 + 2 * i]});
`ifdef LOADER_CHECKSUM_EN
      x = 8'd0;
      for (int j = 1; j <= 2 * n; j++) x = x ^ stream_q[j];
      exp_ok = (x == stream_q[2 * n + 1]);
`else
      x = 8'd0;
      exp_ok = 1'b1;
`endif
    end
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    got_q.delete();
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(byte_ready), 32'd1);
    check("start_cpu_rst", 32'(cpu_rst), 32'd0);
    check("start_done_err", {30'd0, done, err}, 32'd0);
  endtask

  // Send stream_q[first..last-1]; pulse START before index pulse_at (while valid is low).
  task automatic send_range(input int first, input int last, input int max_gap, input int pulse_at);
    int gap;
    int w;
    for (int i = first; i < last; i++) begin
      if (i == pulse_at) begin
        byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_ignored_busy", 32'(busy), 32'd1);
      end
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) begin
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      byte_d = stream_q[i];
      byte_valid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!byte_ready && w < 50);
      if (!byte_ready) begin
        check("accept_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_session(input bit zero_gap);
    int w;
    int n;
    int lat;
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("session_timeout", 32'(busy), 32'd0);
    lat = cyc - t0;
    n = int'(stream_q[0]);
    @(negedge clk);
    check("done", 32'(done), 32'(exp_ok));
    check("err", 32'(err), 32'(!exp_ok));
    check("cpu_rst", 32'(cpu_rst), 32'(exp_ok));
    check("nwrites", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("write", 32'(got_q[i]), 32'(exp_q[i]));
    if (n > 0) check("final_addr", 32'(mem_addr), 32'(n - 1));
`ifdef LOADER_CHECKSUM_EN
    if (zero_gap && exp_ok) check("latency", 32'(lat), 32'(2 + 3 * n));
`else
    if (zero_gap && exp_ok) check("latency", 32'(lat), 32'(1 + 3 * n));
`endif
  endtask

  task automatic run_stream(input int max_gap);
    model_stream();
    start_session();
    send_range(0, stream_q.size(), max_gap, -1);
    finish_session(max_gap == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b, x;

    // Reset values
    #12;
    check("rst_outputs", {24'd0, byte_ready, mem_we, cpu_rst, busy, done, err, 2'b00}, 32'd0);
    check("rst_addr_data", {8'd0, mem_addr, mem_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word image
    stream_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'h40);
`endif
    run_stream(0);

    // Zero length
    stream_q = '{8'h00};
    run_stream(0);

    // Valid held high; with checksum, first try a wrong checksum then the right one
    stream_q = '{8'h01, 8'h55, 8'hAA};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'h00);
    run_stream(0);
    stream_q = '{8'h01, 8'h55, 8'hAA, 8'hFF};
`endif
    run_stream(0);

    // Reset mid-session after three accepted bytes of a two-word image
    stream_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    start_session();
    send_range(0, 3, 0, -1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {24'd0, byte_ready, mem_we, cpu_rst, busy, done, err, 2'b00}, 32'd0);
    check("abort_addr_data", {8'd0, mem_addr, mem_data}, 32'd0);
    check("abort_nwrites", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("abort_write0", 32'(got_q[0]), 32'h001122);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_stream(1);

    // START pulsed while waiting in HI
    stream_q = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02);
`endif
    model_stream();
    start_session();
    send_range(0, stream_q.size(), 0, 1);
    finish_session(1'b0);

    // Random sessions
    for (int s = 0; s < 20; s++) begin
      n = int'($urandom_range(1, 8));
      stream_q.delete();
      stream_q.push_back(8'(n));
      x = 8'd0;
      for (int j = 0; j < 2 * n; j++) begin
        b = 8'($urandom_range(0, 255));
        stream_q.push_back(b);
        x = x ^ b;
      end
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      stream_q.push_back(x);
`endif
      run_stream((s % 3 == 0) ? 0 : 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
